counter_seq_ctrl: RTL and testbench

- Command-driven sequencer for the 32-bit cascaded counter (4-bit slices, rco-chained, slice load flags ANDed into one load flag).
- Accepts one command at a time over a valid/ready handshake: preload a value, then count up or down for a programmed number of cycles.
- Drives the counter's enable/mode/D, checks that the load took effect, counts carry-outs, returns final Q with status.
- Sits between the test/control logic and the counter; it is the only agent driving the counter's control inputs.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/seq_len_timer.sv | 28 ++
 rtl/counter_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the cascaded-counter sequencer: counter mode codes,
// command opcodes and controller state encodings.
package counter_pkg;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [1:0] OP_LOAD_ONLY = 2'b00;
   localparam logic [1:0] OP_LOAD_UP   = 2'b01;
   localparam logic [1:0] OP_LOAD_DOWN = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LWAIT,
      S_RUN,
      S_DONE
   } state_e;

   // Opcode 11 is reserved and behaves like LOAD_ONLY, so it never counts.
   function automatic logic op_counts(input logic [1:0] op);
      return (op == OP_LOAD_UP) || (op == OP_LOAD_DOWN);
   endfunction

endpackage

// File: rtl/seq_len_timer.sv
// Loadable down-counter shared by the load-confirm timeout and the RUN length.
// 'last' flags the cycle whose decrement takes the count to zero.
module seq_len_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         last
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign last = (count_q == W'(1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for the 32-bit cascaded counter: preload, confirm the
// load, count up/down for a programmed length, then report Q and status.
module counter_seq_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned LEN_W   = 16,
   parameter int unsigned WRAP_W  = 8,
   parameter int unsigned LOAD_TO = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [31:0]       cmd_data,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              abort,
   output logic              cnt_enable,
   output logic [1:0]        cnt_mode,
   output logic [31:0]       cnt_D,
   input  logic [31:0]       cnt_Q,
   input  logic              cnt_rco,
   input  logic              cnt_load,
   output logic              busy,
   output logic              done,
   output logic [31:0]       result,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err_load,
   output logic              aborted
);

   state_e state_q, state_d;

   logic [1:0]        op_q;
   logic [31:0]       data_q;
   logic [LEN_W-1:0]  len_q;
   logic              cmd_ready_q, busy_q, done_q, cnt_enable_q;
   logic [1:0]        cnt_mode_q;
   logic [31:0]       result_q;
   logic [WRAP_W-1:0] wrap_q;
   logic              err_load_q, aborted_q, rco_prev_q;

   logic              accept, go_err, go_abort;
   logic              tmr_load, tmr_dec, tmr_last;
   logic [LEN_W-1:0]  tmr_val;
   logic [1:0]        run_mode;

   assign run_mode = (op_q == OP_LOAD_DOWN) ? MODE_DOWN : MODE_UP;

   seq_len_timer #(
      .W (LEN_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .last     (tmr_last)
   );

   // Abort outranks both load timeout and RUN completion.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      go_err   = 1'b0;
      go_abort = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = LEN_W'(LOAD_TO);
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               accept  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            tmr_load = 1'b1;
            if (abort) begin
               go_abort = 1'b1;
               state_d  = S_DONE;
            end else begin
               state_d = S_LWAIT;
            end
         end
         S_LWAIT: begin
            tmr_dec = 1'b1;
            if (abort) begin
               go_abort = 1'b1;
               state_d  = S_DONE;
            end else if (cnt_load) begin
               if (op_counts(op_q) && (len_q != '0)) begin
                  tmr_load = 1'b1;
                  tmr_val  = len_q;
                  state_d  = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end else if (tmr_last) begin
               go_err  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RUN: begin
            tmr_dec = 1'b1;
            if (abort) begin
               go_abort = 1'b1;
               state_d  = S_DONE;
            end else if (tmr_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LOAD_ONLY;
         data_q       <= '0;
         len_q        <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cnt_enable_q <= 1'b0;
         cnt_mode_q   <= MODE_UP;
         result_q     <= '0;
         wrap_q       <= '0;
         err_load_q   <= 1'b0;
         aborted_q    <= 1'b0;
         rco_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= (state_d == S_IDLE);
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
         cnt_enable_q <= (state_d == S_LOAD) || (state_d == S_LWAIT) || (state_d == S_RUN);
         if ((state_d == S_LOAD) || (state_d == S_LWAIT)) begin
            cnt_mode_q <= MODE_LOAD;
         end else if (state_d == S_RUN) begin
            cnt_mode_q <= run_mode;
         end else begin
            cnt_mode_q <= MODE_UP;
         end
         rco_prev_q <= cnt_rco;
         if (accept) begin
            op_q       <= cmd_op;
            data_q     <= cmd_data;
            len_q      <= cmd_len;
            wrap_q     <= '0;
            err_load_q <= 1'b0;
            aborted_q  <= 1'b0;
         end
         if (go_err) begin
            err_load_q <= 1'b1;
         end
         if (go_abort) begin
            aborted_q <= 1'b1;
         end
         if ((state_q == S_RUN) && cnt_rco && !rco_prev_q && (wrap_q != '1)) begin
            wrap_q <= wrap_q + 1'b1;
         end
         if (state_q == S_DONE) begin
            result_q <= cnt_Q;
         end
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cnt_enable = cnt_enable_q;
   assign cnt_mode   = cnt_mode_q;
   assign cnt_D      = data_q;
   assign result     = result_q;
   assign wrap_cnt   = wrap_q;
   assign err_load   = err_load_q;
   assign aborted    = aborted_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 32-bit counter model
// hooked to the controller's counter interface.
module tb_counter_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [31:0] cmd_data = '0;
   logic [15:0] cmd_len = '0;
   logic        abort = 1'b0;
   logic        cnt_enable;
   logic [1:0]  cnt_mode;
   logic [31:0] cnt_D;
   logic [31:0] cnt_Q;
   logic        cnt_rco;
   logic        cnt_load;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [7:0]  wrap_cnt;
   logic        err_load;
   logic        aborted;

   int n_vec  = 0;
   int n_miss = 0;

   // Counter model: mode 11 loads D and raises load next cycle, 00 up, 01 down.
   logic [31:0] mq = '0;
   logic        mload = 1'b0;
   logic        load_stuck = 1'b0;

   always @(posedge clk) begin
      if (cnt_enable && (cnt_mode == 2'b11)) begin
         mq    <= cnt_D;
         mload <= 1'b1;
      end else begin
         mload <= 1'b0;
         if (cnt_enable && (cnt_mode == 2'b00)) mq <= mq + 32'd1;
         if (cnt_enable && (cnt_mode == 2'b01)) mq <= mq - 32'd1;
      end
   end

   assign cnt_Q    = mq;
   assign cnt_load = mload && !load_stuck;
   assign cnt_rco  = ((cnt_mode == 2'b00) && (mq == 32'hFFFF_FFFF)) ||
                     ((cnt_mode == 2'b01) && (mq == 32'h0000_0000));

   counter_seq_ctrl #(
      .LEN_W   (16),
      .WRAP_W  (8),
      .LOAD_TO (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_len    (cmd_len),
      .abort      (abort),
      .cnt_enable (cnt_enable),
      .cnt_mode   (cnt_mode),
      .cnt_D      (cnt_D),
      .cnt_Q      (cnt_Q),
      .cnt_rco    (cnt_rco),
      .cnt_load   (cnt_load),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .wrap_cnt   (wrap_cnt),
      .err_load   (err_load),
      .aborted    (aborted)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called and returning on a falling edge; the next command may start at once.
   task automatic issue(input string name, input logic [1:0] op, input logic [31:0] data,
                        input logic [15:0] len, input int abort_at, input bit keep_valid,
                        input int exp_lat, input int exp_runs, input logic [31:0] exp_res,
                        input logic [7:0] exp_wrap, input logic exp_err, input logic exp_abt);
      int lat;
      int runs;
      check_vec({name, ":ready_idle"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_len   = len;
      @(negedge clk);
      lat  = 1;
      runs = 0;
      if (keep_valid) begin
         cmd_op   = 2'b00;
         cmd_data = 32'hDEAD_BEEF;
         cmd_len  = 16'd0;
      end else begin
         cmd_valid = 1'b0;
      end
      while (!done && (lat < 400)) begin
         if (lat == 2) begin
            check_vec({name, ":lwait_mode"}, 32'(cnt_mode), 32'd3);
            check_vec({name, ":lwait_en"}, 32'(cnt_enable), 32'd1);
            check_vec({name, ":lwait_d"}, cnt_D, data);
            check_vec({name, ":busy_ready"}, 32'(cmd_ready), 32'd0);
         end
         if (cnt_enable && ((cnt_mode == 2'b00) || (cnt_mode == 2'b01))) runs++;
         abort = (lat == abort_at);
         @(negedge clk);
         lat++;
      end
      abort = 1'b0;
      check_vec({name, ":latency"}, 32'(lat), 32'(exp_lat));
      check_vec({name, ":run_cycles"}, 32'(runs), 32'(exp_runs));
      check_vec({name, ":wrap"}, 32'(wrap_cnt), 32'(exp_wrap));
      check_vec({name, ":err_load"}, 32'(err_load), 32'(exp_err));
      check_vec({name, ":aborted"}, 32'(aborted), 32'(exp_abt));
      check_vec({name, ":done_en"}, 32'(cnt_enable), 32'd0);
      check_vec({name, ":done_ready"}, 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check_vec({name, ":result"}, result, exp_res);
      check_vec({name, ":done_pulse"}, 32'(done), 32'd0);
      check_vec({name, ":idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int seen_done;

      repeat (2) @(negedge clk);
      check_vec("rst:ready", 32'(cmd_ready), 32'd1);
      check_vec("rst:busy", 32'(busy), 32'd0);
      check_vec("rst:en", 32'(cnt_enable), 32'd0);
      check_vec("rst:result", result, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      //     name     op     data           len    abt keep lat runs result         wrap err abt
      issue("lonly", 2'b00, 32'h1234_ABCD, 16'd0,   -1, 0,  3,  0,  32'h1234_ABCD, 8'd0, 0, 0);
      issue("up",    2'b01, 32'hFFFF_FFFE, 16'd4,   -1, 0,  7,  4,  32'h0000_0002, 8'd1, 0, 0);
      issue("down",  2'b10, 32'h0000_0010, 16'd16,  -1, 1,  19, 16, 32'h0000_0000, 8'd0, 0, 0);
      issue("b2b",   2'b00, 32'hDEAD_BEEF, 16'd0,   -1, 0,  3,  0,  32'hDEAD_BEEF, 8'd0, 0, 0);
      load_stuck = 1'b1;
      issue("tmo",   2'b01, 32'h55AA_55AA, 16'd8,   -1, 0,  6,  0,  32'h55AA_55AA, 8'd0, 1, 0);
      load_stuck = 1'b0;
      issue("abt",   2'b01, 32'h0000_1000, 16'd100, 4,  0,  5,  2,  32'h0000_1002, 8'd0, 0, 1);
      issue("rsv",   2'b11, 32'h0BAD_F00D, 16'd5,   -1, 0,  3,  0,  32'h0BAD_F00D, 8'd0, 0, 0);

      // Reset in the middle of RUN, after one wrap has been counted.
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = 32'hFFFF_FFFE;
      cmd_len   = 16'd100;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_vec("rstrun:wrap_pre", 32'(wrap_cnt), 32'd1);
      check_vec("rstrun:busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_vec("rstrun:ready", 32'(cmd_ready), 32'd1);
      check_vec("rstrun:busy", 32'(busy), 32'd0);
      check_vec("rstrun:en", 32'(cnt_enable), 32'd0);
      check_vec("rstrun:mode", 32'(cnt_mode), 32'd0);
      check_vec("rstrun:d", cnt_D, 32'd0);
      check_vec("rstrun:result", result, 32'd0);
      check_vec("rstrun:wrap", 32'(wrap_cnt), 32'd0);
      check_vec("rstrun:flags", {30'd0, err_load, aborted}, 32'd0);
      seen_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) seen_done++;
         @(negedge clk);
      end
      check_vec("rstrun:no_done", 32'(seen_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
